// File: rtl/rom_load_pkg.sv
// Shared types, state codes and region map helpers for the ROM download sequencer.
// Optional checksum support lives in rom_load_seq under ROM_LOAD_CHECKSUM_EN.
package rom_load_pkg;

  localparam int unsigned ADDR_W       = 25;
  localparam int unsigned DEF_CPU_SIZE = 16384;
  localparam int unsigned DEF_GFX_SIZE = 4096;
  localparam int unsigned DEF_PAL_SIZE = 32;

  typedef logic [2:0] state_t;
  localparam state_t ST_BOOT  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_RUN   = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_CPU  = 2'd1,
    REG_GFX  = 2'd2,
    REG_PAL  = 2'd3
  } region_e;

  function automatic int unsigned gfx_base(input int unsigned cpu_size);
    return cpu_size;
  endfunction

  function automatic int unsigned pal_base(input int unsigned cpu_size, input int unsigned gfx_size);
    return cpu_size + gfx_size;
  endfunction

  function automatic int unsigned total_size(input int unsigned cpu_size, input int unsigned gfx_size,
                                             input int unsigned pal_size);
    return cpu_size + gfx_size + pal_size;
  endfunction

  // Regions are packed back to back starting at byte 0: CPU, then GFX, then PAL.
  function automatic region_e region_of(input logic [ADDR_W-1:0] addr, input int unsigned cpu_size,
                                        input int unsigned gfx_size, input int unsigned pal_size);
    logic [31:0] a;
    a = 32'(addr);
    if (a < cpu_size) return REG_CPU;
    if (a < pal_base(cpu_size, gfx_size)) return REG_GFX;
    if (a < total_size(cpu_size, gfx_size, pal_size)) return REG_PAL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte address into its ROM region and
// region-relative offset.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter int unsigned CPU_SIZE = DEF_CPU_SIZE,
  parameter int unsigned GFX_SIZE = DEF_GFX_SIZE,
  parameter int unsigned PAL_SIZE = DEF_PAL_SIZE
) (
  input  logic [24:0] addr,
  output logic [1:0]  region,
  output logic [15:0] offset
);

  // Region offsets always fit in 16 bits, so a 16-bit subtract is exact.
  localparam logic [15:0] GFX_BASE16 = 16'(gfx_base(CPU_SIZE));
  localparam logic [15:0] PAL_BASE16 = 16'(pal_base(CPU_SIZE, GFX_SIZE));

  region_e sel;

  assign sel    = region_of(addr, CPU_SIZE, GFX_SIZE, PAL_SIZE);
  assign region = sel;

  always_comb begin
    offset = addr[15:0];
    case (sel)
      REG_GFX: offset = addr[15:0] - GFX_BASE16;
      REG_PAL: offset = addr[15:0] - PAL_BASE16;
      default: offset = addr[15:0];
    endcase
  end

endmodule

// File: rtl/rom_load_seq.sv
// ROM download sequencer: routes HPS download bytes to region write strobes,
// validates the image and holds the game core in reset until it is good.
// Define ROM_LOAD_CHECKSUM_EN to also require an 8-bit additive checksum match.
module rom_load_seq
  import rom_load_pkg::*;
#(
  parameter int unsigned CPU_SIZE    = DEF_CPU_SIZE,
  parameter int unsigned GFX_SIZE    = DEF_GFX_SIZE,
  parameter int unsigned PAL_SIZE    = DEF_PAL_SIZE,
  parameter int unsigned HOLD_CYCLES = 255,
  parameter logic [7:0]  EXP_SUM     = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic        core_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        pal_we,
  output logic        busy,
  output logic        load_ok,
  output logic        load_err,
  output logic [2:0]  fsm_state
);

  localparam int unsigned TOTAL     = total_size(CPU_SIZE, GFX_SIZE, PAL_SIZE);
  localparam logic [16:0] TOTAL_CNT = 17'(TOTAL);
  localparam logic [16:0] HOLD_INIT = 17'(HOLD_CYCLES - 1);

  state_t      state, state_nx;
  logic [16:0] cnt;
  logic        ovf;
  logic [1:0]  region;
  logic [15:0] offset;
  logic        accept, hit, enter_load, sum_ok, image_good;

  rom_region_decode #(
    .CPU_SIZE (CPU_SIZE),
    .GFX_SIZE (GFX_SIZE),
    .PAL_SIZE (PAL_SIZE)
  ) u_decode (
    .addr   (ioctl_addr),
    .region (region),
    .offset (offset)
  );

  // Handshake: ioctl_wr is a one-cycle valid with no ready; every write seen in
  // LOAD while ioctl_download is high is taken, all others are dropped.
  assign accept     = (state == ST_LOAD) && ioctl_download && ioctl_wr;
  assign hit        = accept && (region != REG_NONE);
  assign enter_load = (state_nx == ST_LOAD) && (state != ST_LOAD);

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] sum;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)        sum <= 8'd0;
    else if (enter_load) sum <= 8'd0;
    else if (hit)        sum <= sum + ioctl_dout;
  end
  assign sum_ok = (sum == EXP_SUM);
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^EXP_SUM;
  assign sum_ok         = 1'b1;
`endif

  assign image_good = (cnt == TOTAL_CNT) && !ovf && sum_ok;

  always_comb begin
    state_nx = state;
    case (state)
      ST_BOOT:  if (ioctl_download) state_nx = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_nx = ST_CHECK;
      ST_CHECK: state_nx = image_good ? ST_HOLD : ST_ERR;
      ST_HOLD: begin
        if (ioctl_download)                 state_nx = ST_LOAD;
        else if (!ext_reset && cnt == '0)   state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (ioctl_download) state_nx = ST_LOAD;
        else if (ext_reset) state_nx = ST_HOLD;
      end
      ST_ERR:   if (ioctl_download) state_nx = ST_LOAD;
      default:  state_nx = ST_BOOT;
    endcase
  end

  // cnt counts accepted bytes in LOAD and counts down the settle time in HOLD.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BOOT;
      cnt      <= '0;
      ovf      <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (enter_load) begin
        cnt      <= '0;
        ovf      <= 1'b0;
        load_ok  <= 1'b0;
        load_err <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (hit && cnt != '1) cnt <= cnt + 17'd1;
            if (accept && !hit)   ovf <= 1'b1;
          end
          ST_CHECK: begin
            load_ok  <= image_good;
            load_err <= !image_good;
            cnt      <= HOLD_INIT;
          end
          ST_HOLD: begin
            if (ext_reset)       cnt <= HOLD_INIT;
            else if (cnt != '0)  cnt <= cnt - 17'd1;
          end
          ST_RUN:  if (ext_reset) cnt <= HOLD_INIT;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_we  <= 1'b0;
      gfx_we  <= 1'b0;
      pal_we  <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
    end else begin
      cpu_we <= hit && (region == REG_CPU);
      gfx_we <= hit && (region == REG_GFX);
      pal_we <= hit && (region == REG_PAL);
      if (hit) begin
        dn_addr <= offset;
        dn_data <= ioctl_dout;
      end
    end
  end

  assign core_reset = (state != ST_RUN);
  assign busy       = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_HOLD);
  assign fsm_state  = state;

endmodule
